// File: rtl/icache_refill_wr_sched_pkg.sv
// Shared types for the I-cache refill write scheduler.
package icache_refill_pkg;

    localparam int unsigned REFILL_ADDR_WIDTH = 5;
    localparam int unsigned REFILL_DATA_WIDTH = 32;
    localparam int unsigned REFILL_FIFO_DEPTH = 4;

    // One buffered refill beat at the default array geometry
    typedef struct packed {
        logic [REFILL_ADDR_WIDTH-1:0] addr;
        logic [REFILL_DATA_WIDTH-1:0] data;
    } refill_entry_t;

    // Scheduler activity state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/refill_fifo_2pop.sv
// Circular refill buffer: one push and up to two pops per cycle, with flush.
module refill_fifo_2pop #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               push,
    input  logic [ADDR_WIDTH-1:0]              push_addr,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic [1:0]                         pop,
    output logic [CW-1:0]                      count,
    output logic [CW-1:0]                      count_next,
    output logic [ADDR_WIDTH-1:0]              head_addr,
    output logic [DATA_WIDTH-1:0]              head_data,
    output logic [ADDR_WIDTH-1:0]              next_addr,
    output logic [DATA_WIDTH-1:0]              next_data,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]   entry_addr,
    output logic [DEPTH-1:0]                   entry_valid
);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_mem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_mem;
    logic [PW-1:0]                    rd_ptr;
    logic [PW-1:0]                    wr_ptr;
    logic [PW-1:0]                    rd_ptr_next;

    assign rd_ptr_next = rd_ptr + PW'(1);
    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign next_addr   = addr_mem[rd_ptr_next];
    assign next_data   = data_mem[rd_ptr_next];
    assign entry_addr  = addr_mem;
    assign count_next  = flush ? '0 : (count + CW'(push) - CW'(pop));

    // A slot is live when its distance from the read pointer is below count
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] offset;
        assign offset         = PW'(i) - rd_ptr;
        assign entry_valid[i] = CW'(offset) < count;
    end

    // Storage, pointers and occupancy; flush empties the buffer but keeps storage
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            addr_mem <= '0;
            data_mem <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count_next;
        end
    end

endmodule

// File: rtl/icache_refill_wr_sched.sv
// Write-side scheduler for the I-cache 2R/2W array: buffers refill beats,
// issues up to two writes per cycle and flags reads of pending words.
module icache_refill_wr_sched import icache_refill_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = REFILL_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = REFILL_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = REFILL_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  refill_valid_i,
    output logic                  refill_ready_o,
    input  logic [ADDR_WIDTH-1:0] refill_addr_i,
    input  logic [DATA_WIDTH-1:0] refill_data_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    input  logic [ADDR_WIDTH-1:0] chk_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] chk_addr_b_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,
    output logic                  idle_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]                         count;
    logic [CW-1:0]                         count_next;
    logic                                  push;
    logic                                  issue;
    logic [1:0]                            pop;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic                                  inflight_a_valid;
    logic                                  inflight_b_valid;
    logic [ADDR_WIDTH-1:0]                 inflight_a_addr;
    logic [ADDR_WIDTH-1:0]                 inflight_b_addr;
    state_t                                state_q;

    assign refill_ready_o = count < CW'(FIFO_DEPTH);
    assign push           = refill_valid_i && refill_ready_o && !flush_i;
    assign issue          = !stall_i && !flush_i;
    assign we_a_o         = issue && (count != '0);
    assign we_b_o         = issue && (count >= CW'(2));
    assign pop            = {1'b0, we_a_o} + {1'b0, we_b_o};
    assign idle_o         = (state_q == IDLE);

    refill_fifo_2pop #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush_i),
        .push        (push),
        .push_addr   (refill_addr_i),
        .push_data   (refill_data_i),
        .pop         (pop),
        .count       (count),
        .count_next  (count_next),
        .head_addr   (waddr_a_o),
        .head_data   (wdata_a_o),
        .next_addr   (waddr_b_o),
        .next_data   (wdata_b_o),
        .entry_addr  (entry_addr),
        .entry_valid (entry_valid)
    );

    // Remember last cycle's issued addresses while the array commits them
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_a_valid <= 1'b0;
            inflight_b_valid <= 1'b0;
            inflight_a_addr  <= '0;
            inflight_b_addr  <= '0;
        end else begin
            inflight_a_valid <= we_a_o;
            inflight_b_valid <= we_b_o;
            inflight_a_addr  <= waddr_a_o;
            inflight_b_addr  <= waddr_b_o;
        end
    end

    // Compare both read addresses against every queued and in-flight write
    always_comb begin
        hazard_a_o = (inflight_a_valid && (inflight_a_addr == chk_addr_a_i)) ||
                     (inflight_b_valid && (inflight_b_addr == chk_addr_a_i));
        hazard_b_o = (inflight_a_valid && (inflight_a_addr == chk_addr_b_i)) ||
                     (inflight_b_valid && (inflight_b_addr == chk_addr_b_i));
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == chk_addr_a_i)) begin
                hazard_a_o = 1'b1;
            end
            if (entry_valid[i] && (entry_addr[i] == chk_addr_b_i)) begin
                hazard_b_o = 1'b1;
            end
        end
    end

    // Activity FSM; leaving ACTIVE covers both the last pop and a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (push) state_q <= ACTIVE;
                ACTIVE:  if (count_next == '0) state_q <= DRAIN;
                DRAIN:   state_q <= push ? ACTIVE : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_wr_sched.sv
// Scoreboard bench for icache_refill_wr_sched: accepted beats are queued and
// retired against the write ports; occupancy, hazards and idle are modelled.
module tb_icache_refill_wr_sched;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    typedef enum int {S_IDLE, S_ACTIVE, S_DRAIN} mstate_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          refill_valid = 1'b0;
    logic          refill_ready;
    logic [AW-1:0] refill_addr = '0;
    logic [DW-1:0] refill_data = '0;
    logic          flush = 1'b0;
    logic          stall = 1'b0;
    logic          we_a, we_b;
    logic [AW-1:0] waddr_a, waddr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [AW-1:0] chk_a = 5'd31;
    logic [AW-1:0] chk_b = 5'd30;
    logic          hazard_a, hazard_b;
    logic          idle;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Bench-side model state
    beat_t         q[$];
    bit            mon_en = 1'b0;
    mstate_t       st = S_IDLE;
    logic          infl_a_v = 1'b0, infl_b_v = 1'b0;
    logic [AW-1:0] infl_a = '0, infl_b = '0;
    logic [DW-1:0] arr [32];
    int unsigned   m_cnt;
    logic          m_ewa, m_ewb, m_ha, m_hb, m_acc;
    beat_t         m_ea, m_eb;

    icache_refill_wr_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .refill_valid_i (refill_valid),
        .refill_ready_o (refill_ready),
        .refill_addr_i  (refill_addr),
        .refill_data_i  (refill_data),
        .flush_i        (flush),
        .stall_i        (stall),
        .we_a_o         (we_a),
        .waddr_a_o      (waddr_a),
        .wdata_a_o      (wdata_a),
        .we_b_o         (we_b),
        .waddr_b_o      (waddr_b),
        .wdata_b_o      (wdata_b),
        .chk_addr_a_i   (chk_a),
        .chk_addr_b_i   (chk_b),
        .hazard_a_o     (hazard_a),
        .hazard_b_o     (hazard_b),
        .idle_o         (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle model: check this cycle's outputs, then advance to the next edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            infl_a_v = 1'b0;
            infl_b_v = 1'b0;
            st = S_IDLE;
        end else if (mon_en) begin
            m_cnt = q.size();
            m_ewa = !stall && !flush && (m_cnt >= 1);
            m_ewb = !stall && !flush && (m_cnt >= 2);
            check("ready", refill_ready, m_cnt < DEPTH);
            check("we_a", we_a, m_ewa);
            check("we_b", we_b, m_ewb);
            check("idle", idle, st == S_IDLE);
            m_ha = (infl_a_v && infl_a == chk_a) || (infl_b_v && infl_b == chk_a);
            m_hb = (infl_a_v && infl_a == chk_b) || (infl_b_v && infl_b == chk_b);
            foreach (q[i]) begin
                if (q[i].a == chk_a) m_ha = 1'b1;
                if (q[i].a == chk_b) m_hb = 1'b1;
            end
            check("hazard_a", hazard_a, m_ha);
            check("hazard_b", hazard_b, m_hb);
            infl_a_v = m_ewa;
            infl_b_v = m_ewb;
            if (m_ewa) begin
                m_ea = q.pop_front();
                check("waddr_a", waddr_a, m_ea.a);
                check("wdata_a", wdata_a, m_ea.d);
                infl_a = m_ea.a;
                arr[waddr_a] = wdata_a;
            end
            if (m_ewb) begin
                m_eb = q.pop_front();
                check("waddr_b", waddr_b, m_eb.a);
                check("wdata_b", wdata_b, m_eb.d);
                infl_b = m_eb.a;
                arr[waddr_b] = wdata_b;
            end
            if (flush) q.delete();
            m_acc = refill_valid && (m_cnt < DEPTH) && !flush;
            if (m_acc) q.push_back('{refill_addr, refill_data});
            case (st)
                S_IDLE:   if (m_acc) st = S_ACTIVE;
                S_ACTIVE: if (q.size() == 0) st = S_DRAIN;
                default:  st = m_acc ? S_ACTIVE : S_IDLE;
            endcase
        end
    end

    // Hold a beat until the handshake completes, bounded
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic done;
        done = 1'b0;
        refill_valid = 1'b1;
        refill_addr  = a;
        refill_data  = d;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (refill_ready && !flush) done = 1'b1;
            @(posedge clk);
            #1;
        end
        refill_valid = 1'b0;
        check("send_accept", done, 1'b1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) arr[i] = '0;
        step(3);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_waddr_a", waddr_a, 0);
        check("rst_wdata_a", wdata_a, 0);
        check("rst_waddr_b", waddr_b, 0);
        check("rst_wdata_b", wdata_b, 0);
        check("rst_ready", refill_ready, 1);
        check("rst_idle", idle, 1);
        step(1);

        // Single beat
        send(5'd3, 32'hA5A5_0003);
        @(negedge clk);
        check("single_we_a", we_a, 1);
        check("single_waddr", waddr_a, 3);
        check("single_we_b", we_b, 0);
        @(negedge clk);
        check("single_drain", idle, 0);
        @(negedge clk);
        check("single_idle", idle, 1);
        step(1);

        // Unstalled burst of 8
        for (int i = 0; i < 8; i++) send(AW'(i), 32'hB000_0000 + 32'(i));
        step(3);

        // Fill under stall, then drain with wrap
        stall = 1'b1;
        for (int i = 0; i < 4; i++) send(AW'(10 + i), 32'hC000_0000 + 32'(i));
        @(negedge clk);
        check("full_ready", refill_ready, 0);
        step(1);
        refill_valid = 1'b1;
        refill_addr  = 5'd14;
        refill_data  = 32'hC000_0004;
        step(2);
        stall = 1'b0;
        send(5'd14, 32'hC000_0004);
        for (int i = 0; i < 4; i++) send(AW'(15 + i), 32'hD000_0000 + 32'(i));
        step(4);

        // Same address in one pop: port B carries the younger beat
        stall = 1'b1;
        send(5'd9, 32'h0000_1111);
        send(5'd9, 32'h0000_2222);
        stall = 1'b0;
        @(negedge clk);
        check("pair_waddr_a", waddr_a, 9);
        check("pair_wdata_a", wdata_a, 32'h1111);
        check("pair_waddr_b", waddr_b, 9);
        check("pair_wdata_b", wdata_b, 32'h2222);
        step(3);
        check("pair_array", arr[9], 32'h2222);

        // Hazard lifetime: queued, issuing, in flight, cleared
        chk_a = 5'd6;
        stall = 1'b1;
        send(5'd6, 32'hE000_0006);
        @(negedge clk);
        check("haz_queued", hazard_a, 1);
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        check("haz_issue", hazard_a, 1);
        @(negedge clk);
        check("haz_inflight", hazard_a, 1);
        @(negedge clk);
        check("haz_clear", hazard_a, 0);
        chk_a = 5'd31;
        step(2);

        // Flush with 3 queued and a concurrent push
        stall = 1'b1;
        for (int i = 0; i < 3; i++) send(AW'(20 + i), 32'hF000_0000 + 32'(i));
        flush        = 1'b1;
        refill_valid = 1'b1;
        refill_addr  = 5'd23;
        refill_data  = 32'hF000_0003;
        @(negedge clk);
        check("flush_no_we", we_a, 0);
        step(1);
        flush        = 1'b0;
        refill_valid = 1'b0;
        @(negedge clk);
        check("flush_drain", idle, 0);
        check("flush_empty_ready", refill_ready, 1);
        @(negedge clk);
        check("flush_idle", idle, 1);
        step(1);
        stall = 1'b0;
        step(2);

        // Reset with beats queued
        stall = 1'b1;
        for (int i = 0; i < 3; i++) send(AW'(24 + i), 32'h7000_0000 + 32'(i));
        rst = 1'b1;
        step(1);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("rst_mid_we", we_a, 0);
        check("rst_mid_waddr", waddr_a, 0);
        check("rst_mid_idle", idle, 1);
        step(1);

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            refill_valid = 1'($urandom_range(0, 1));
            refill_addr  = AW'($urandom_range(0, 7));
            refill_data  = $urandom;
            stall        = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            chk_a        = AW'($urandom_range(0, 7));
            chk_b        = AW'($urandom_range(0, 7));
            step(1);
        end
        refill_valid = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        step(6);
        @(negedge clk);
        check("final_idle", idle, 1);
        check("final_ready", refill_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
